// File: rtl/i2c_master_mg_if.sv
// Client request/response and byte-engine command bus of the TCPM-side I2C transaction manager.
interface i2c_master_mg_if;
  logic       REQ;
  logic       RNW;
  logic [7:0] ADDR;
  logic [7:0] WR_DATA;
  logic [7:0] RD_DATA;
  logic       ACK;
  logic       ERR;
  logic       BUSY;
  logic       CMD_VALID;
  logic [1:0] CMD;
  logic [7:0] TX_BYTE;
  logic       MASTER_NACK;
  logic       CMD_DONE;
  logic [7:0] RX_BYTE;
  logic       SLAVE_NACK;

  modport master (
    input  REQ, RNW, ADDR, WR_DATA, CMD_DONE, RX_BYTE, SLAVE_NACK,
    output RD_DATA, ACK, ERR, BUSY, CMD_VALID, CMD, TX_BYTE, MASTER_NACK
  );

  modport slave (
    output REQ, RNW, ADDR, WR_DATA, CMD_DONE, RX_BYTE, SLAVE_NACK,
    input  RD_DATA, ACK, ERR, BUSY, CMD_VALID, CMD, TX_BYTE, MASTER_NACK
  );
endinterface

// File: rtl/i2c_master_mg.sv
// Single-register I2C read/write sequencer: drives a byte-level master engine through
// START / address / data / repeated-START / STOP and returns data plus an error flag.
module i2c_master_mg #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic            CLK,
  input  logic            RESET,
  i2c_master_mg_if.master bus
);
  // counter only ever holds 0..TIMEOUT-1; the wait that would make it reach TIMEOUT aborts
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {C_START = 2'd0, C_WRITE = 2'd1, C_READ = 2'd2, C_STOP = 2'd3} cmd_e;

  typedef enum logic [4:0] {
    IDLE,
    START_I, START_W, DEVW_I, DEVW_W, REG_I, REG_W,
    WDAT_I, WDAT_W,
    RST_I, RST_W, DEVR_I, DEVR_W, RDAT_I, RDAT_W,
    STOP_I, STOP_W, RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          rnw_q, rnw_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    rd_q, rd_d;

  logic          cmd_valid, mnack, issue, in_wait, can_nack;
  logic [1:0]    cmd;
  logic [7:0]    tx;
  state_e        ok_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      hold_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    hold_d    = hold_q;
    rd_d      = rd_q;
    cmd_valid = 1'b0;
    cmd       = 2'd0;
    tx        = 8'h00;
    mnack     = 1'b0;
    issue     = 1'b0;
    in_wait   = 1'b0;
    can_nack  = 1'b0;
    ok_nxt    = IDLE;

    unique case (state_q)
      IDLE: if (bus.REQ) begin
        rnw_d   = bus.RNW;
        addr_d  = bus.ADDR;
        wdat_d  = bus.WR_DATA;
        state_d = START_I;
      end
      START_I: begin issue = 1'b1; cmd = C_START; state_d = START_W; end
      START_W: begin in_wait = 1'b1; ok_nxt = DEVW_I; end
      DEVW_I:  begin issue = 1'b1; cmd = C_WRITE; tx = {SLAVE_ADDR, 1'b0}; state_d = DEVW_W; end
      DEVW_W:  begin in_wait = 1'b1; can_nack = 1'b1; ok_nxt = REG_I; end
      REG_I:   begin issue = 1'b1; cmd = C_WRITE; tx = addr_q; state_d = REG_W; end
      REG_W:   begin in_wait = 1'b1; can_nack = 1'b1; ok_nxt = rnw_q ? RST_I : WDAT_I; end
      WDAT_I:  begin issue = 1'b1; cmd = C_WRITE; tx = wdat_q; state_d = WDAT_W; end
      WDAT_W:  begin in_wait = 1'b1; can_nack = 1'b1; ok_nxt = STOP_I; end
      RST_I:   begin issue = 1'b1; cmd = C_START; state_d = RST_W; end
      RST_W:   begin in_wait = 1'b1; ok_nxt = DEVR_I; end
      DEVR_I:  begin issue = 1'b1; cmd = C_WRITE; tx = {SLAVE_ADDR, 1'b1}; state_d = DEVR_W; end
      DEVR_W:  begin in_wait = 1'b1; can_nack = 1'b1; ok_nxt = RDAT_I; end
      // single-byte read: master NACKs the only byte so the slave releases SDA for STOP
      RDAT_I:  begin issue = 1'b1; cmd = C_READ; mnack = 1'b1; state_d = RDAT_W; end
      RDAT_W:  begin
        in_wait = 1'b1;
        ok_nxt  = STOP_I;
        if (bus.CMD_DONE) hold_d = bus.RX_BYTE;
      end
      STOP_I:  begin issue = 1'b1; cmd = C_STOP; state_d = STOP_W; end
      STOP_W:  begin in_wait = 1'b1; ok_nxt = RESP; end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      cmd_valid = 1'b1;
      cnt_d     = '0;
    end

    if (in_wait) begin
      if (bus.CMD_DONE) begin
        if (can_nack && bus.SLAVE_NACK) begin
          err_d   = 1'b1;
          state_d = STOP_I;
        end else begin
          state_d = ok_nxt;
        end
      end else if (cnt_q == TMO_LAST) begin
        // a stuck STOP cannot be retried, so give up straight to the response
        err_d   = 1'b1;
        state_d = (state_q == STOP_W) ? RESP : STOP_I;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (state_d == RESP && rnw_q && !err_d) rd_d = hold_q;
    if (state_d == IDLE) err_d = 1'b0;
  end

  assign bus.CMD_VALID   = cmd_valid;
  assign bus.CMD         = cmd;
  assign bus.TX_BYTE     = tx;
  assign bus.MASTER_NACK = mnack;
  assign bus.ACK         = (state_q == RESP);
  assign bus.ERR         = (state_q == RESP) && err_q;
  assign bus.BUSY        = (state_q != IDLE);
  assign bus.RD_DATA     = rd_q;
endmodule

// File: tb/tb_i2c_master_mg.sv
// Bench for i2c_master_mg: a reactive byte-engine model answers commands, and each
// transaction is checked against an expected command list, latency, ERR and RD_DATA.
module tb_i2c_master_mg;
  localparam int         TO = 20;
  localparam logic [6:0] SA = 7'h50;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  i2c_master_mg_if bus ();

  i2c_master_mg #(.SLAVE_ADDR(SA), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] tx;
    logic       mn;
    int         cy;
  } ent_t;

  // engine behaviour, indexed by position of the command within the transaction
  int         e_delay[8];
  bit         e_never[8];
  bit         e_nack[8];
  logic [7:0] e_rx;

  ent_t       log_q[$];
  ent_t       exp_q[$];
  bit         exp_err;
  int         exp_lat;
  logic [7:0] rd_model;

  int  cnt_dn;
  int  cur_idx;
  bit  pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // byte engine: answers each command after e_delay cycles, or never
  initial begin : engine
    ent_t e;
    bus.CMD_DONE   = 1'b0;
    bus.RX_BYTE    = 8'h00;
    bus.SLAVE_NACK = 1'b0;
    pend = 1'b0;
    forever begin
      @(negedge CLK);
      bus.CMD_DONE   = 1'b0;
      bus.SLAVE_NACK = 1'b0;
      if (RESET) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt_dn--;
          if (cnt_dn == 0) begin
            pend           = 1'b0;
            bus.CMD_DONE   = 1'b1;
            bus.RX_BYTE    = e_rx;
            bus.SLAVE_NACK = e_nack[cur_idx];
          end
        end
        if (bus.CMD_VALID) begin
          e.cmd = bus.CMD; e.tx = bus.TX_BYTE; e.mn = bus.MASTER_NACK; e.cy = cyc;
          log_q.push_back(e);
          cur_idx = log_q.size() - 1;
          if (cur_idx < 8 && !e_never[cur_idx]) begin
            pend   = 1'b1;
            cnt_dn = e_delay[cur_idx];
          end
        end
      end
    end
  end

  function automatic ent_t mk(input logic [1:0] c, input logic [7:0] t, input logic m);
    ent_t e;
    e.cmd = c; e.tx = t; e.mn = m; e.cy = 0;
    return e;
  endfunction

  function automatic int cost(input int i);
    return e_never[i] ? TO + 1 : e_delay[i] + 1;
  endfunction

  // expected outcome from the protocol rules: nominal command list, cut short by the
  // first NACKed byte or stuck command, which is followed by a lone STOP
  function automatic void model(input bit rnw, input logic [7:0] addr, input logic [7:0] wd);
    ent_t nom[$];
    int   i;
    nom.push_back(mk(2'd0, 8'h00, 1'b0));
    nom.push_back(mk(2'd1, {SA, 1'b0}, 1'b0));
    nom.push_back(mk(2'd1, addr, 1'b0));
    if (rnw) begin
      nom.push_back(mk(2'd0, 8'h00, 1'b0));
      nom.push_back(mk(2'd1, {SA, 1'b1}, 1'b0));
      nom.push_back(mk(2'd2, 8'h00, 1'b1));
    end else begin
      nom.push_back(mk(2'd1, wd, 1'b0));
    end
    nom.push_back(mk(2'd3, 8'h00, 1'b0));
    exp_q.delete();
    exp_err = 1'b0;
    exp_lat = 1;
    for (int j = 0; j < nom.size(); j++) begin
      i = exp_q.size();
      exp_q.push_back(nom[j]);
      exp_lat += cost(i);
      if (nom[j].cmd == 2'd3) begin
        if (e_never[i]) exp_err = 1'b1;
        break;
      end
      if (e_never[i] || (nom[j].cmd == 2'd1 && e_nack[i])) begin
        exp_err = 1'b1;
        exp_q.push_back(mk(2'd3, 8'h00, 1'b0));
        exp_lat += cost(i + 1);
        break;
      end
    end
  endfunction

  task automatic cfg(input int d);
    for (int i = 0; i < 8; i++) begin
      e_delay[i] = d; e_never[i] = 1'b0; e_nack[i] = 1'b0;
    end
  endtask

  // waits for ACK of a transaction accepted in cycle acc and checks it
  task automatic wait_check(input int acc, input bit rnw, input string tag, input bit hold,
                            output int ackc);
    bit got = 1'b0;
    ackc = -1;
    for (int i = 0; i < 4000; i++) begin
      if (bus.ACK) begin got = 1'b1; break; end
      @(negedge CLK);
    end
    chk({tag, ".ack_seen"}, 32'(got), 32'd1);
    if (!hold) bus.REQ = 1'b0;
    if (got) begin
      ackc = cyc;
      if (rnw && !exp_err) rd_model = e_rx;
      chk({tag, ".latency"}, 32'(ackc - acc), 32'(exp_lat));
      chk({tag, ".err"}, 32'(bus.ERR), 32'(exp_err));
      chk({tag, ".rd_data"}, 32'(bus.RD_DATA), 32'(rd_model));
      chk({tag, ".ncmds"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
        chk($sformatf("%s.cmd%0d", tag, i), 32'(log_q[i].cmd), 32'(exp_q[i].cmd));
        if (exp_q[i].cmd == 2'd1)
          chk($sformatf("%s.tx%0d", tag, i), 32'(log_q[i].tx), 32'(exp_q[i].tx));
        if (exp_q[i].cmd == 2'd2)
          chk($sformatf("%s.mnack%0d", tag, i), 32'(log_q[i].mn), 32'(exp_q[i].mn));
      end
    end
    if (!hold) begin
      @(negedge CLK);
      chk({tag, ".ack_pulse"}, 32'(bus.ACK), 32'd0);
      chk({tag, ".idle"}, 32'(bus.BUSY), 32'd0);
    end
  endtask

  task automatic do_txn(input bit rnw, input logic [7:0] addr, input logic [7:0] wd,
                        input string tag, input bit hold, output int ackc);
    int acc;
    @(negedge CLK);
    log_q.delete();
    model(rnw, addr, wd);
    bus.RNW = rnw; bus.ADDR = addr; bus.WR_DATA = wd; bus.REQ = 1'b1;
    acc = cyc;
    @(negedge CLK);
    chk({tag, ".busy"}, 32'(bus.BUSY), 32'd1);
    // inputs after acceptance must be ignored
    bus.RNW = ~rnw; bus.ADDR = 8'($urandom); bus.WR_DATA = 8'($urandom);
    wait_check(acc, rnw, tag, hold, ackc);
  endtask

  initial begin : stim
    int   ackc, sc, acks, k;
    bit   rnw, got;
    bus.REQ = 1'b0; bus.RNW = 1'b0; bus.ADDR = 8'h00; bus.WR_DATA = 8'h00;
    cfg(1); e_rx = 8'h00; rd_model = 8'h00;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst.busy", 32'(bus.BUSY), 32'd0);
    chk("rst.ack", 32'(bus.ACK), 32'd0);
    chk("rst.err", 32'(bus.ERR), 32'd0);
    chk("rst.cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    chk("rst.cmd", 32'(bus.CMD), 32'd0);
    chk("rst.tx_byte", 32'(bus.TX_BYTE), 32'd0);
    chk("rst.mnack", 32'(bus.MASTER_NACK), 32'd0);
    chk("rst.rd_data", 32'(bus.RD_DATA), 32'd0);
    RESET = 1'b0;

    cfg(1); e_rx = 8'h77;
    do_txn(1'b0, 8'h10, 8'hA5, "wr_ok", 1'b0, ackc);
    cfg(1); e_rx = 8'h5C;
    do_txn(1'b1, 8'h2E, 8'h00, "rd_ok", 1'b0, ackc);
    cfg(1); e_nack[1] = 1'b1; e_rx = 8'h3B;
    do_txn(1'b1, 8'h41, 8'h00, "addr_nack", 1'b0, ackc);
    cfg(2); e_nack[3] = 1'b1;
    do_txn(1'b0, 8'h05, 8'hC3, "data_nack", 1'b0, ackc);
    cfg(1); e_never[2] = 1'b1; e_never[3] = 1'b1;
    do_txn(1'b0, 8'h22, 8'h11, "timeout", 1'b0, ackc);

    for (int n = 0; n < 14; n++) begin
      rnw = 1'($urandom);
      for (int i = 0; i < 8; i++) begin
        e_delay[i] = $urandom_range(1, 3); e_never[i] = 1'b0; e_nack[i] = 1'b0;
      end
      e_rx = 8'($urandom);
      case ($urandom % 6)
        0: begin
          k = $urandom_range(1, 3);
          if (rnw && k == 3) k = 4;
          e_nack[k] = 1'b1;
        end
        1: e_never[$urandom_range(0, rnw ? 6 : 4)] = 1'b1;
        default: ;
      endcase
      do_txn(rnw, 8'($urandom), 8'($urandom), $sformatf("rnd%0d", n), 1'b0, ackc);
    end

    // reset while waiting on the read byte
    cfg(1); e_never[5] = 1'b1; e_rx = 8'hE1;
    @(negedge CLK);
    log_q.delete();
    bus.RNW = 1'b1; bus.ADDR = 8'h13; bus.REQ = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      bus.REQ = 1'b0;
      if (log_q.size() >= 6) begin got = 1'b1; break; end
    end
    chk("rst_mid.reached_rdata", 32'(got), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    rd_model = 8'h00;
    chk("rst_mid.busy", 32'(bus.BUSY), 32'd0);
    chk("rst_mid.cmd_valid", 32'(bus.CMD_VALID), 32'd0);
    chk("rst_mid.rd_data", 32'(bus.RD_DATA), 32'd0);
    chk("rst_mid.ack", 32'(bus.ACK), 32'd0);
    RESET = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.ACK || bus.CMD_VALID) acks++;
    end
    chk("rst_mid.quiet", 32'(acks), 32'd0);

    // REQ held through ACK: the IDLE cycle re-accepts, START follows it
    cfg(1); e_rx = 8'h9E;
    do_txn(1'b0, 8'h33, 8'h44, "b2b1", 1'b1, ackc);
    log_q.delete();
    bus.RNW = 1'b1; bus.ADDR = 8'h07; bus.WR_DATA = 8'h00;
    model(1'b1, 8'h07, 8'h00);
    got = 1'b0; sc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.CMD_VALID) begin got = 1'b1; sc = cyc; break; end
    end
    chk("b2b2.start_seen", 32'(got), 32'd1);
    chk("b2b2.start_cycle", 32'(sc - ackc), 32'd2);
    chk("b2b2.start_cmd", 32'(bus.CMD), 32'd0);
    bus.REQ = 1'b0;
    wait_check(ackc + 1, 1'b1, "b2b2", 1'b0, sc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
